// File: rtl/nes_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nes_ctrl_pkg
// Shared definitions for the NES joypad responder:
//   - btn_e        : bit position of each NES button in the 8-bit button word
//   - KEY_*        : USB HID usage codes that drive each button
//   - CTRL*_ADDR   : CPU addresses of the two controller ports
//   - OPEN_BUS_HI  : upper read-data bits that the NES bus leaves floating high
//   - map_keycode  : combinational keycode -> button word translation
// ---------------------------------------------------------------------------
package nes_ctrl_pkg;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_e;

    localparam logic [7:0] KEY_X     = 8'h1B;
    localparam logic [7:0] KEY_Z     = 8'h1D;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_D     = 8'h07;

    localparam logic [15:0] CTRL1_ADDR  = 16'h4016;
    localparam logic [15:0] CTRL2_ADDR  = 16'h4017;
    localparam logic [7:0]  OPEN_BUS_HI = 8'h40;

    // Only one key is reported at a time, so at most one button is raised.
    function automatic logic [7:0] map_keycode(input logic [7:0] code);
        logic [7:0] btn;
        btn = '0;
        case (code)
            KEY_X:               btn[BTN_A]      = 1'b1;
            KEY_Z:               btn[BTN_B]      = 1'b1;
            KEY_SPACE:           btn[BTN_SELECT] = 1'b1;
            KEY_ENTER:           btn[BTN_START]  = 1'b1;
            KEY_UP,    KEY_W:    btn[BTN_UP]     = 1'b1;
            KEY_DOWN,  KEY_S:    btn[BTN_DOWN]   = 1'b1;
            KEY_LEFT,  KEY_A:    btn[BTN_LEFT]   = 1'b1;
            KEY_RIGHT, KEY_D:    btn[BTN_RIGHT]  = 1'b1;
            default: ;
        endcase
        return btn;
    endfunction

endpackage

// File: rtl/nes_controller_port_stretch.sv
// ---------------------------------------------------------------------------
// key_stretch
// Holds one button asserted for STRETCH_CYCLES clocks after its key is last
// seen, so a short key tap survives until the game polls the pad.
// Runs every clock, independent of the CPU clock enable.
// Ports:
//   Clk     in  system clock
//   Reset   in  synchronous, active-high
//   raw     in  unstretched button from the key map
//   button  out stretched button (high while the hold counter is non-zero)
// ---------------------------------------------------------------------------
module key_stretch #(
    parameter int STRETCH_CYCLES = 357954
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic button
);

    localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // A held key keeps re-arming the counter; on release it counts down to 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= '0;
        end else if (raw) begin
            cnt <= CNT_MAX;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign button = (cnt != '0);

endmodule

// File: rtl/nes_controller_port.sv
// ---------------------------------------------------------------------------
// nes_controller_port
// Responder for the NES joypad registers $4016/$4017. Translates the SOC
// keycode into the 8 NES buttons, stretches short taps, latches the buttons
// while the strobe is high and shifts them out one bit per $4016 read.
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous, active-high
//   cpu_ce        in   one-clock pulse per CPU cycle; qualifies the bus
//   cpu_addr      in   CPU address [15:0]
//   cpu_rw_n      in   1 = read, 0 = write
//   cpu_wdata     in   CPU write data [7:0]
//   keycode       in   current USB HID usage, 0x00 = no key
//   cpu_rdata     out  read data, combinational
//   cpu_rdata_en  out  read-mux select for $4016/$4017 reads
//   buttons_dbg   out  stretched buttons {Right,Left,Down,Up,Start,Select,B,A}
// ---------------------------------------------------------------------------
module nes_controller_port
    import nes_ctrl_pkg::*;
#(
    parameter int STRETCH_CYCLES = 357954,
    parameter int PORT2_PRESENT  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw_n,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  keycode,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_en,
    output logic [7:0]  buttons_dbg
);

    logic [7:0] raw_btn;
    logic [7:0] buttons;

    logic       strobe;
    logic [7:0] shift_reg;
    logic [3:0] read_cnt;

    logic       sel1;
    logic       sel2;
    logic       rd1;
    logic       rd2;
    logic       wr1;
    logic       port1_bit;
    logic       port2_bit;
    logic [6:0] unused_wdata;

    assign raw_btn = map_keycode(keycode);

    key_stretch #(
        .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_stretch [7:0] (
        .Clk    (Clk),
        .Reset  (Reset),
        .raw    (raw_btn),
        .button (buttons)
    );

    assign buttons_dbg = buttons;

    // Address decode. The mux select ignores cpu_ce so the bus mux can be
    // set up before the enable pulse; state changes need cpu_ce.
    assign sel1 = (cpu_addr == CTRL1_ADDR);
    assign sel2 = (cpu_addr == CTRL2_ADDR);
    assign rd1  = cpu_ce &  cpu_rw_n & sel1;
    assign rd2  = cpu_ce &  cpu_rw_n & sel2;
    assign wr1  = cpu_ce & ~cpu_rw_n & sel1;

    assign cpu_rdata_en = cpu_rw_n & (sel1 | sel2);

    // Only bit 0 of the $4016 write is the strobe.
    assign unused_wdata = cpu_wdata[7:1];

    // With strobe high the pad is transparent and reports live A. After eight
    // shifts a real pad reports 1s, which read_cnt reproduces explicitly.
    always_comb begin
        port1_bit = 1'b1;
        if (strobe) begin
            port1_bit = buttons[BTN_A];
        end else if (read_cnt < 4'd8) begin
            port1_bit = shift_reg[0];
        end
    end

    assign port2_bit = (PORT2_PRESENT != 0) ? port1_bit : 1'b0;

    always_comb begin
        cpu_rdata = OPEN_BUS_HI;
        if (rd1) begin
            cpu_rdata = OPEN_BUS_HI | {7'b0, port1_bit};
        end else if (rd2) begin
            cpu_rdata = OPEN_BUS_HI | {7'b0, port2_bit};
        end
    end

    // The shift lands on the clock that ends the read cycle, so the CPU has
    // already sampled the pre-shift bit. The reload while strobe is high uses
    // the registered strobe, so the clock that clears it still reloads once.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            strobe    <= 1'b0;
            shift_reg <= 8'h00;
            read_cnt  <= 4'd0;
        end else begin
            if (wr1) begin
                strobe <= cpu_wdata[0];
            end
            if (strobe) begin
                shift_reg <= buttons;
                read_cnt  <= 4'd0;
            end else if (rd1) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                if (read_cnt != 4'd8) begin
                    read_cnt <= read_cnt + 4'd1;
                end
            end
        end
    end

endmodule
